// File: rtl/nx_indirect_access_arb.sv
// rtl/nx_indirect_access_arb.sv - HW/SW arbiter for one shared single-port array
//
// Purpose:
//   Shares a single-port register/memory array between a datapath engine
//   (hw_*) and the software indirect-access controller (sw_*). Hardware has
//   priority. While software waits, hardware gets at most MAX_HW_BURST further
//   accesses before ownership switches. A software grant that is held for
//   SW_TIMEOUT cycles without a yield is revoked, and err_timeout pulses.
//   Every software ownership period ends with one RELEASE cycle in which the
//   array is idle, so a read issued in the last granted cycle can still
//   return to sw_rdat.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   sw_req            controller wants the array (level)
//   grant             controller owns the array
//   yield             controller releases the array (pulse, only while granted)
//   sw_cs/sw_we/sw_add/sw_wdat   SW access, honoured only while granted
//   sw_rdat           SW read data, valid the cycle after the SW read
//   hw_req/hw_we/hw_add/hw_wdat  HW access request
//   hw_ack            HW request accepted this cycle (combinational)
//   hw_rvalid/hw_rdat HW read data, one cycle after the accepted read
//   mem_cs/mem_we/mem_add/mem_wdat/mem_rdat   array port, 1-cycle read latency
//   err_timeout       1-cycle pulse on a forced revoke
module nx_indirect_access_arb #(
  parameter int N_DATA_BITS  = 64,
  parameter int N_ADDR_BITS  = 5,
  parameter int MAX_HW_BURST = 8,
  parameter int SW_TIMEOUT   = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sw_req,
  output logic                   grant,
  input  logic                   yield,
  input  logic                   sw_cs,
  input  logic                   sw_we,
  input  logic [N_ADDR_BITS-1:0] sw_add,
  input  logic [N_DATA_BITS-1:0] sw_wdat,
  output logic [N_DATA_BITS-1:0] sw_rdat,
  input  logic                   hw_req,
  input  logic                   hw_we,
  input  logic [N_ADDR_BITS-1:0] hw_add,
  input  logic [N_DATA_BITS-1:0] hw_wdat,
  output logic                   hw_ack,
  output logic                   hw_rvalid,
  output logic [N_DATA_BITS-1:0] hw_rdat,
  output logic                   mem_cs,
  output logic                   mem_we,
  output logic [N_ADDR_BITS-1:0] mem_add,
  output logic [N_DATA_BITS-1:0] mem_wdat,
  input  logic [N_DATA_BITS-1:0] mem_rdat,
  output logic                   err_timeout
);

  localparam int BURST_W = $clog2(MAX_HW_BURST + 1);
  localparam int HOLD_W  = $clog2(SW_TIMEOUT + 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_HW_BURST);
  localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(SW_TIMEOUT);

  typedef enum logic [1:0] {
    HW_OWN  = 2'd0,
    SW_OWN  = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [BURST_W-1:0]   r_burst_cnt;
  logic [BURST_W-1:0]   w_burst_nxt;
  logic [HOLD_W-1:0]    r_hold_cnt;
  logic [HOLD_W-1:0]    w_hold_nxt;

  // Read-return tracking: one outstanding read, tagged with its owner.
  logic                 r_rd_pend;
  logic                 r_rd_sw;
  logic [N_DATA_BITS-1:0] r_sw_rdat;
  logic [N_DATA_BITS-1:0] r_hw_rdat;

  logic                 w_switch;
  logic                 w_hw_ack;
  logic                 w_timeout;
  logic                 w_sw_sel;
  logic                 w_hw_sel;
  logic                 w_rd_issue;

  // Next-state, counters and access selection.
  always_comb begin
    w_state_nxt = r_state;
    w_burst_nxt = r_burst_cnt;
    w_hold_nxt  = r_hold_cnt;
    w_switch    = 1'b0;
    w_hw_ack    = 1'b0;
    w_timeout   = 1'b0;
    w_sw_sel    = 1'b0;
    w_hw_sel    = 1'b0;

    case (r_state)
      HW_OWN: begin
        w_hold_nxt = '0;
        // SW takes over when HW is idle or has used up its burst allowance.
        w_switch = sw_req & (~hw_req | (r_burst_cnt == BURST_MAX));
        w_hw_ack = hw_req & ~w_switch;
        w_hw_sel = w_hw_ack;
        if (w_switch) begin
          w_state_nxt = SW_OWN;
          w_burst_nxt = '0;
        end else if (!sw_req) begin
          w_burst_nxt = '0;
        end else if (w_hw_ack && (r_burst_cnt != BURST_MAX)) begin
          w_burst_nxt = r_burst_cnt + 1'b1;
        end
      end

      SW_OWN: begin
        w_sw_sel = sw_cs;
        if (r_hold_cnt != HOLD_MAX) begin
          w_hold_nxt = r_hold_cnt + 1'b1;
        end
        // A yield in the timeout cycle wins: it is a clean release.
        if (yield) begin
          w_state_nxt = RELEASE;
        end else if (r_hold_cnt == HOLD_MAX) begin
          w_timeout   = 1'b1;
          w_state_nxt = RELEASE;
        end
      end

      RELEASE: begin
        w_hold_nxt  = '0;
        w_state_nxt = HW_OWN;
      end

      default: begin
        w_state_nxt = HW_OWN;
        w_burst_nxt = '0;
        w_hold_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= HW_OWN;
      r_burst_cnt <= '0;
      r_hold_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_burst_cnt <= w_burst_nxt;
      r_hold_cnt  <= w_hold_nxt;
    end
  end

  // Array port: at most one of the two selects is active in any cycle.
  assign mem_cs   = w_hw_sel | w_sw_sel;
  assign mem_we   = w_sw_sel ? sw_we   : (w_hw_sel & hw_we);
  assign mem_add  = w_sw_sel ? sw_add  : hw_add;
  assign mem_wdat = w_sw_sel ? sw_wdat : hw_wdat;

  assign w_rd_issue = mem_cs & ~mem_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_pend <= 1'b0;
      r_rd_sw   <= 1'b0;
      r_sw_rdat <= '0;
      r_hw_rdat <= '0;
    end else begin
      r_rd_pend <= w_rd_issue;
      r_rd_sw   <= w_sw_sel;
      if (r_rd_pend && r_rd_sw) begin
        r_sw_rdat <= mem_rdat;
      end
      if (r_rd_pend && !r_rd_sw) begin
        r_hw_rdat <= mem_rdat;
      end
    end
  end

  // Returning data is forwarded straight from the array in its return cycle
  // and held in the owner's register afterwards.
  assign hw_rvalid   = r_rd_pend & ~r_rd_sw;
  assign sw_rdat     = (r_rd_pend & r_rd_sw) ? mem_rdat : r_sw_rdat;
  assign hw_rdat     = hw_rvalid ? mem_rdat : r_hw_rdat;

  assign grant       = (r_state == SW_OWN);
  assign hw_ack      = w_hw_ack;
  assign err_timeout = w_timeout;

endmodule

// File: tb/tb_nx_indirect_access_arb.sv
// tb/tb_nx_indirect_access_arb.sv - randomized self-checking bench for nx_indirect_access_arb
module tb_nx_indirect_access_arb;

  localparam int DW    = 64;
  localparam int AW    = 5;
  localparam int BURST = 8;
  localparam int TMO   = 255;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sw_req, grant, yield, sw_cs, sw_we;
  logic [AW-1:0] sw_add;
  logic [DW-1:0] sw_wdat, sw_rdat;
  logic          hw_req, hw_we, hw_ack, hw_rvalid;
  logic [AW-1:0] hw_add;
  logic [DW-1:0] hw_wdat, hw_rdat;
  logic          mem_cs, mem_we;
  logic [AW-1:0] mem_add;
  logic [DW-1:0] mem_wdat, mem_rdat;
  logic          err_timeout;

  always #5 clk = ~clk;

  nx_indirect_access_arb #(
    .N_DATA_BITS(DW), .N_ADDR_BITS(AW), .MAX_HW_BURST(BURST), .SW_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .sw_req(sw_req), .grant(grant), .yield(yield),
    .sw_cs(sw_cs), .sw_we(sw_we), .sw_add(sw_add), .sw_wdat(sw_wdat), .sw_rdat(sw_rdat),
    .hw_req(hw_req), .hw_we(hw_we), .hw_add(hw_add), .hw_wdat(hw_wdat),
    .hw_ack(hw_ack), .hw_rvalid(hw_rvalid), .hw_rdat(hw_rdat),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_add(mem_add), .mem_wdat(mem_wdat),
    .mem_rdat(mem_rdat), .err_timeout(err_timeout)
  );

  // Array behind the arbiter: single port, registered read.
  logic [DW-1:0] env_mem [32];
  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_we) env_mem[mem_add] <= mem_wdat;
      else        mem_rdat <= env_mem[mem_add];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns the array, how long, how much HW has been
  // served while SW waits, plus a shadow copy of the array contents.
  bit            m_grant, m_release, m_hw_rv;
  int            m_streak, m_age;
  logic [DW-1:0] shadow [32];
  logic [DW-1:0] m_sw_rdat, m_hw_rdat;

  // Last observed values, for scenario-level checks.
  bit            o_ack, o_grant, o_tmo;
  logic [DW-1:0] o_hw_rdat;

  task automatic model_reset();
    m_grant = 0; m_release = 0; m_hw_rv = 0;
    m_streak = 0; m_age = 0;
    m_sw_rdat = '0; m_hw_rdat = '0;
  endtask

  // One clock cycle: inputs are already applied; check at negedge, advance
  // the model, return 1 time unit after the next posedge.
  task automatic cyc();
    bit e_ack, e_tmo, e_sw_win, e_cs, e_we;
    logic [AW-1:0] e_add;
    logic [DW-1:0] e_wd;
    e_ack = 0; e_tmo = 0; e_sw_win = 0;
    if (m_grant) begin
      e_tmo = !yield && (m_age == TMO);
    end else if (!m_release) begin
      e_sw_win = sw_req && (!hw_req || (m_streak >= BURST));
      e_ack    = hw_req && !e_sw_win;
    end
    e_cs  = e_ack || (m_grant && sw_cs);
    e_we  = e_ack ? hw_we   : sw_we;
    e_add = e_ack ? hw_add  : sw_add;
    e_wd  = e_ack ? hw_wdat : sw_wdat;

    @(negedge clk);
    chk("grant", grant, m_grant);
    chk("hw_ack", hw_ack, e_ack);
    chk("err_timeout", err_timeout, e_tmo);
    chk("mem_cs", mem_cs, e_cs);
    if (e_cs) begin
      chk("mem_we", mem_we, e_we);
      chk("mem_add", mem_add, e_add);
      if (e_we) chk("mem_wdat", mem_wdat, e_wd);
    end
    chk("hw_rvalid", hw_rvalid, m_hw_rv);
    chk("hw_rdat", hw_rdat, m_hw_rdat);
    chk("sw_rdat", sw_rdat, m_sw_rdat);
    o_ack = hw_ack; o_grant = grant; o_tmo = err_timeout; o_hw_rdat = hw_rdat;

    m_hw_rv = 0;
    if (e_cs) begin
      if (e_we)       shadow[e_add] = e_wd;
      else if (e_ack) begin m_hw_rdat = shadow[e_add]; m_hw_rv = 1; end
      else            m_sw_rdat = shadow[e_add];
    end
    if (m_release) begin
      m_release = 0;
    end else if (m_grant) begin
      if (yield || m_age == TMO) begin m_grant = 0; m_release = 1; m_age = 0; end
      else m_age++;
    end else if (e_sw_win) begin
      m_grant = 1; m_age = 0; m_streak = 0;
    end else if (!sw_req) begin
      m_streak = 0;
    end else if (e_ack) begin
      m_streak++;
    end

    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    sw_req = 0; yield = 0; sw_cs = 0; sw_we = 0; sw_add = '0; sw_wdat = '0;
    hw_req = 0; hw_we = 0; hw_add = '0; hw_wdat = '0;
  endtask

  task automatic hw_rand(input bit req);
    hw_req  = req;
    hw_we   = 1'($urandom_range(0, 1));
    hw_add  = AW'($urandom_range(0, 31));
    hw_wdat = {$urandom(), $urandom()};
  endtask

  initial begin
    int n_burst;
    int gc;
    bit seen;
    idle_inputs();
    model_reset();
    rst_n = 1;
    #2 rst_n = 0;

    // Reset state
    @(negedge clk);
    chk("rst_grant", grant, 1'b0);
    chk("rst_hw_rvalid", hw_rvalid, 1'b0);
    chk("rst_err_timeout", err_timeout, 1'b0);
    chk("rst_sw_rdat", sw_rdat, '0);
    chk("rst_hw_rdat", hw_rdat, '0);
    chk("rst_mem_cs", mem_cs, 1'b0);
    @(posedge clk);
    #1 rst_n = 1;

    // Fill the array through the HW port
    for (int a = 0; a < 32; a++) begin
      hw_req = 1; hw_we = 1; hw_add = AW'(a); hw_wdat = {$urandom(), $urandom()};
      cyc();
    end

    // HW only: 20 back-to-back reads, addresses 0..19
    for (int a = 0; a < 20; a++) begin
      hw_req = 1; hw_we = 0; hw_add = AW'(a);
      cyc();
    end
    hw_req = 0;
    cyc();
    cyc();

    // SW request under continuous HW load: exactly BURST more HW acks
    n_burst = 0;
    sw_req = 1;
    for (int i = 0; i < 30 && !m_grant; i++) begin
      hw_rand(1'b1);
      hw_we = 0;
      cyc();
      if (o_ack) n_burst++;
    end
    chk("burst_acks", 64'(n_burst), 64'(BURST));
    sw_cs = 1; sw_we = 0; sw_add = 5'd5;
    cyc();
    sw_cs = 1; sw_we = 1; sw_add = 5'd31; sw_wdat = 64'hDEADBEEF;
    cyc();
    sw_cs = 0; yield = 1; sw_req = 0;
    cyc();
    yield = 0; hw_req = 1; hw_we = 0; hw_add = 5'd31;
    cyc();                      // RELEASE cycle, HW held off
    cyc();                      // HW read of 31 accepted
    hw_req = 0;
    cyc();
    chk("hw_rd31", o_hw_rdat, 64'hDEADBEEF);

    // SW request with HW idle: grant on the next cycle
    sw_req = 1;
    cyc();
    cyc();
    chk("fast_grant", o_grant, 1'b1);
    yield = 1; sw_req = 0;
    cyc();
    yield = 0;
    cyc();

    // Never-yielding SW: forced revoke in grant cycle SW_TIMEOUT+1
    gc = 0; seen = 0;
    sw_req = 1;
    for (int i = 0; i < 400 && !seen; i++) begin
      cyc();
      if (o_grant) gc++;
      if (o_tmo) seen = 1;
    end
    chk("tmo_seen", seen, 1'b1);
    chk("tmo_cycle", 64'(gc), 64'(TMO + 1));
    sw_req = 0;
    cyc();
    chk("tmo_grant_drop", o_grant, 1'b0);
    hw_req = 1; hw_we = 0; hw_add = 5'd7;
    cyc();
    cyc();
    chk("hw_after_tmo", o_ack, 1'b1);
    hw_req = 0;

    // Yield in the timeout cycle: plain release, no error
    sw_req = 1;
    for (int i = 0; i < 5 && !m_grant; i++) cyc();
    for (int i = 0; i < 300 && m_grant && m_age < TMO; i++) cyc();
    yield = 1;
    cyc();
    chk("tmo_on_yield", o_tmo, 1'b0);
    yield = 0; sw_req = 0;
    cyc();

    // Async reset in SW_OWN with a SW read in flight
    sw_req = 1;
    for (int i = 0; i < 5 && !m_grant; i++) cyc();
    sw_cs = 1; sw_we = 0; sw_add = 5'd3;
    cyc();
    rst_n = 0;
    #1;
    chk("arst_grant", grant, 1'b0);
    chk("arst_hw_rvalid", hw_rvalid, 1'b0);
    chk("arst_sw_rdat", sw_rdat, '0);
    model_reset();
    sw_req = 0;
    @(negedge clk);
    chk("arst_sw_cs_no_mem_cs", mem_cs, 1'b0);
    rst_n = 1;
    @(posedge clk);
    #1;
    cyc();
    sw_cs = 0;
    cyc();

    // Async reset with a HW read in flight
    hw_req = 1; hw_we = 0; hw_add = 5'd9;
    cyc();
    rst_n = 0; hw_req = 0;
    #1;
    chk("arst_hw_inflight", hw_rvalid, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    cyc();
    cyc();

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      hw_rand($urandom_range(0, 3) != 0);
      sw_we   = 1'($urandom_range(0, 1));
      sw_add  = AW'($urandom_range(0, 31));
      sw_wdat = {$urandom(), $urandom()};
      if (m_grant) begin
        sw_cs = 1'($urandom_range(0, 1));
        yield = ($urandom_range(0, 15) == 0);
      end else begin
        yield = 0;
        sw_cs = ($urandom_range(0, 3) == 0);
        if (m_release)    sw_req = 1'($urandom_range(0, 1));
        else if (!sw_req) sw_req = ($urandom_range(0, 15) == 0);
      end
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/nx_indirect_access_arb.md
Name: nx_indirect_access_arb

Overview:
- Arbiter that shares one single-port register/memory array between a hardware engine requester and the software indirect-access controller.
- The controller reaches the array through its sw_cs/sw_we/sw_add/sw_wdat/sw_rdat and grant/yield interface.
- Hardware has priority, with a bounded burst so software is never starved. A software-hold watchdog revokes a grant that is never yielded.
- Sits between the indirect-access controller and the array wrapper in each block that exposes a table to both CSR software and datapath logic.

Parameters:
N_DATA_BITS, 64, array word width
N_ADDR_BITS, 5, array address width
MAX_HW_BURST, 8, consecutive HW accesses allowed while SW is waiting (>=1)
SW_TIMEOUT, 255, cycles SW may hold grant before forced revoke (>=2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
sw_req  in  1  controller wants the array (level, held until yield)
grant  out  1  controller owns the array
yield  in  1  controller releases the array (1-cycle pulse, only meaningful while grant=1)
sw_cs  in  1  SW access strobe (valid only while grant=1)
sw_we  in  1  SW write enable
sw_add  in  N_ADDR_BITS  SW address
sw_wdat  in  N_DATA_BITS  SW write data
sw_rdat  out  N_DATA_BITS  SW read data, 1 cycle after the sw_cs read
hw_req  in  1  HW access request
hw_we  in  1  HW write enable
hw_add  in  N_ADDR_BITS  HW address
hw_wdat  in  N_DATA_BITS  HW write data
hw_ack  out  1  HW request accepted this cycle (combinational)
hw_rvalid  out  1  HW read data valid
hw_rdat  out  N_DATA_BITS  HW read data
mem_cs, mem_we  out  1  array strobe and write enable
mem_add  out  N_ADDR_BITS  array address
mem_wdat  out  N_DATA_BITS  array write data
mem_rdat  in  N_DATA_BITS  array read data, 1-cycle latency
err_timeout  out  1  1-cycle pulse on a forced revoke

Behaviour:
- Reset (async, rst_n=0):
  - State HW_OWN; burst and hold counters 0.
  - grant=0, err_timeout=0, hw_rvalid=0.
  - sw_rdat and hw_rdat are 0.
  - mem_cs=0 combinationally whenever no access is selected.
- Counter widths: $clog2(limit+1). Counters saturate and never wrap.
- State HW_OWN (grant=0):
  - hw_ack = hw_req & ~switch.
  - switch = sw_req & (~hw_req | burst_cnt==MAX_HW_BURST).
  - When hw_ack=1, mem_* = hw_*.
  - burst_cnt increments on each hw_ack while sw_req=1, and clears when sw_req=0.
  - On switch: next state SW_OWN, grant=1 from the next cycle, burst_cnt cleared, and no HW access in the switch cycle.
- State SW_OWN (grant=1):
  - hw_ack=0. mem_* = sw_* gated by sw_cs.
  - hold_cnt increments every cycle.
  - If yield=1: next state RELEASE.
  - Else if hold_cnt==SW_TIMEOUT: err_timeout pulses and next state RELEASE. The forced revoke does not wait for sw_req to drop.
  - sw_cs while grant=0 is ignored: no memory access and sw_rdat unchanged.
- State RELEASE (one cycle):
  - grant=0, hw_ack=0, no memory access. This lets the last SW read return.
  - hold_cnt cleared; next state HW_OWN.
  - If sw_req is still high on re-entry to HW_OWN, normal arbitration applies.
- Read return:
  - A 1-bit owner flag and a valid flag are registered on each mem_cs & ~mem_we.
  - Next cycle, mem_rdat is loaded into sw_rdat or hw_rdat according to the owner flag.
  - hw_rvalid pulses 1 cycle after a HW read ack.
  - sw_rdat holds its value until the next SW read.
- Writes: no read return and no rvalid.
- Simultaneous yield and timeout in the same cycle: treat as yield, no err_timeout.
- Reset mid-operation: everything returns to reset values immediately. In-flight read data is discarded (no rvalid).

Test Plan:
- HW only, no SW: hw_req held for 20 cycles of reads to addresses 0..19 -> hw_ack every cycle. hw_rvalid each cycle from cycle 2 with hw_rdat = mem[addr], grant stays 0.
- SW request under continuous HW load, MAX_HW_BURST=8: exactly 8 further hw_acks, then 1 switch cycle, then grant=1. SW read of addr 5 returns mem[5] next cycle. yield leads to 1 RELEASE cycle, then hw_ack resumes.
- SW request with hw_req low: grant=1 on the next cycle.
- SW write 0xDEADBEEF to addr 31, yield, HW read of addr 31 -> hw_rdat=0xDEADBEEF.
- SW_TIMEOUT=255, SW never yields: err_timeout pulses in cycle 256 of grant, grant drops the next cycle, HW is served afterwards. yield and timeout in the same cycle gives no err_timeout.
- Async reset asserted while in SW_OWN with a read in flight: grant=0 and hw_rvalid=0 immediately, and no stale rvalid after deassertion. sw_cs with grant=0 produces no mem_cs.
